// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-side program counter owner.
// Advances the PC one word per cycle and holds it on a decode stall.
// A taken branch or jump resolved in DX loads its target, and the block
// squashes the FD and DX slots in the same cycle.
// BOOT gives one quiet cycle after reset.
// SHADOW ignores the one decision that comes from the squashed slot.
// Optional build macro REDIRECT_STATS_EN adds the redirectCount and
// shadowDropCount saturating statistics outputs.
module pc_redirect_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              isBranch,
    input  logic [ADDR_W-1:0] addrBranch,
    input  logic              isJump,
    input  logic [ADDR_W-1:0] addrJump,
    output logic [ADDR_W-1:0] pcOut,
    output logic              pcValid,
    output logic              flushFD,
    output logic              flushDX,
    output logic              conflict
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]       redirectCount,
    output logic [15:0]       shadowDropCount
`endif
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SHADOW = 2'd2;

    logic [1:0]        state;
    logic              redirect;
    logic              accept;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pcInc;

    // Branch wins over jump when both resolve in the same cycle.
    assign redirect = isBranch | isJump;
    assign target   = isBranch ? addrBranch : addrJump;
    assign pcInc    = pcOut + ADDR_W'(1);

    // Only a RUN-state decision is real; reset masks any flush outright.
    assign accept  = reset && (state == RUN) && redirect;
    assign flushFD = accept;
    assign flushDX = accept;

    // PC, valid, conflict and state sequencing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= BOOT;
            pcOut    <= RESET_PC;
            pcValid  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    pcValid <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        pcOut <= target;
                        state <= SHADOW;
                        if (isBranch && isJump) begin
                            conflict <= 1'b1;
                        end
                    end else if (!stall) begin
                        pcOut <= pcInc;
                    end
                end
                SHADOW: begin
                    state <= RUN;
                    if (!stall) begin
                        pcOut <= pcInc;
                    end
                end
                default: begin
                    state   <= BOOT;
                    pcOut   <= RESET_PC;
                    pcValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    function automatic logic [31:0] satInc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    // Saturating counts of accepted redirects and of decisions dropped in SHADOW.
    always_ff @(posedge clock) begin
        if (!reset) begin
            redirectCount   <= '0;
            shadowDropCount <= '0;
        end else begin
            if (accept) begin
                redirectCount <= satInc32(redirectCount);
            end
            if ((state == SHADOW) && redirect) begin
                shadowDropCount <= satInc16(shadowDropCount);
            end
        end
    end
`endif

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the execute-stage branch/jump decision in the 5-stage pipeline.
- Owns the program counter and advances it by one word per cycle.
- On a taken branch or jump resolved in DX, it loads the target and squashes the two wrong-path instructions in FD and DX.
- A one-cycle shadow state and a boot state give deterministic restart after reset and redirect.

Parameters:
- ADDR_W, 32: PC and target width in bits (word addressed).
- RESET_PC, 0: PC value loaded by reset.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  reset, synchronous and active-low (0 = in reset).
- stall  input  1  hazard stall from decode; holds the PC when no redirect is pending.
- isBranch  input  1  taken conditional branch resolved in DX.
- addrBranch  input  ADDR_W  branch target (PC plus sign-extended immediate).
- isJump  input  1  unconditional jump resolved in DX.
- addrJump  input  ADDR_W  jump target.
- pcOut  output  ADDR_W  registered fetch address.
- pcValid  output  1  registered; high when pcOut is a real fetch.
- flushFD  output  1  combinational; squash the FD latch at the next edge.
- flushDX  output  1  combinational; squash the DX latch at the next edge.
- conflict  output  1  registered; sticky; isBranch and isJump were both high in one RUN cycle.

Behaviour:
- State machine has three states: BOOT, RUN and SHADOW.
- Reset, sampled at a rising edge while reset=0, has priority over everything:
  - pcOut=RESET_PC, pcValid=0, conflict=0, state=BOOT.
  - flushFD=flushDX=0 forced while reset=0.
- BOOT lasts exactly one cycle after reset releases:
  - pcOut is held at RESET_PC and pcValid=0.
  - isBranch, isJump and stall are ignored.
  - Next state is RUN with pcValid=1, pcOut=RESET_PC.
- RUN, redirect = isBranch | isJump:
  - If redirect: flushFD=flushDX=1 in the same cycle, target loads into pcOut at the next edge, next state is SHADOW. Redirect overrides stall.
  - If isBranch and isJump are both high, addrBranch wins and conflict is set (cleared only by reset).
  - If no redirect and stall=1: pcOut is held; flushes stay 0.
  - Otherwise: pcOut <= pcOut + 1, modulo 2^ADDR_W, so all-ones wraps to 0.
- SHADOW lasts exactly one cycle:
  - isBranch and isJump are ignored, because they come from a squashed slot, and flushes stay 0.
  - pcOut <= pcOut + 1 unless stall=1, in which case it is held.
  - Next state is RUN.
- pcValid is 1 in RUN and SHADOW, and 0 in BOOT and during reset.
- Redirect latency:
  - Decision sampled in cycle N means pcOut equals the target in cycle N+1.
  - The earliest next redirect is accepted in cycle N+2.
- Reset asserted in SHADOW or mid-stall returns to BOOT with no residual flush.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- When defined, the block adds these registered outputs:
  - redirectCount[31:0]: increments once per accepted redirect and saturates at all-ones.
  - shadowDropCount[15:0]: increments when isBranch|isJump is high in SHADOW and saturates.
  - Both counters reset to 0.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset: reset=0 for 3 cycles, then release → pcOut=0, pcValid=0 through BOOT. Then pcOut=0,1,2,3 on the following cycles with pcValid=1 and flushes 0.
- Stall at pcOut=5: stall=1 for 2 cycles → pcOut stays 5, 5, then 6 after stall drops, and flushFD/flushDX never assert.
- Branch at pcOut=8 with isBranch=1, addrBranch=0x40 → flushFD=flushDX=1 in that cycle and pcOut=0x40 next. In SHADOW, isBranch=1 with addrBranch=0x99 is ignored and pcOut=0x41. With the stats macro, redirectCount=1 and shadowDropCount=1.
- Redirect under stall: stall=1, isJump=1, addrJump=0x100 → flushes high and pcOut=0x100 next cycle.
- Conflict and wrap: isBranch=isJump=1 with addrBranch=0x20, addrJump=0x30 → pcOut=0x20 and conflict=1 sticky. Separately, pcOut=0xFFFFFFFF with no stall → pcOut=0.
- Reset mid-SHADOW: branch to 0x40, then reset=0 in the SHADOW cycle → pcOut=0, pcValid=0, state BOOT, flushes 0 and conflict=0.
